// File: rtl/recorder_port_serializer.sv
// Buffers recorder playback words in a small FIFO and emits them one port
// sample per beat on a valid/ready stream, skipping ports disabled in port_mask.
module recorder_port_serializer #(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned DROP_CNT_WIDTH = 16,
  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1,
  localparam int unsigned WW = NUM_PORTS * DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      in_valid,
  input  logic [WW-1:0]             in_data,
  input  logic [NUM_PORTS-1:0]      port_mask,
  input  logic                      clear,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [PW-1:0]             out_port,
  output logic                      out_last,
  output logic [LW-1:0]             fifo_level,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state;
  logic [WW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [WW-1:0]        hold_word;
  logic [NUM_PORTS-1:0] hold_mask;

  logic          fifo_empty, fifo_full, fire, word_done;
  logic          do_load, do_write, do_drop;
  logic [WW-1:0] head;
  logic [PW-1:0] lo_new, hi_new, nx_idx, hi_hold;

  function automatic logic [PW-1:0] lowest_set(input logic [NUM_PORTS-1:0] m);
    logic [PW-1:0] r;
    logic          found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!found && m[i]) begin
        r     = PW'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] highest_set(input logic [NUM_PORTS-1:0] m);
    logic [PW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (m[i]) r = PW'(i);
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] next_above(input logic [NUM_PORTS-1:0] m,
                                               input logic [PW-1:0]        cur);
    logic [PW-1:0] r;
    logic          found;
    r     = cur;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!found && m[i] && (i > 32'(cur))) begin
        r     = PW'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Port 0 occupies the most significant lane of the word.
  function automatic logic [DATA_WIDTH-1:0] lane(input logic [WW-1:0] w,
                                                 input logic [PW-1:0] p);
    return w[(NUM_PORTS - 1 - 32'(p)) * DATA_WIDTH +: DATA_WIDTH];
  endfunction

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
  assign fire       = out_valid && out_ready;
  assign word_done  = (state == IDLE) || (fire && out_last);
  // A new word is only started with a usable mask; a zero mask parks words in the FIFO.
  assign do_load    = !clear && word_done && !fifo_empty && (port_mask != '0);
  assign do_write   = !clear && in_valid && !fifo_full;
  assign do_drop    = !clear && in_valid && fifo_full;

  assign head    = mem[rd_ptr];
  assign lo_new  = lowest_set(port_mask);
  assign hi_new  = highest_set(port_mask);
  assign nx_idx  = next_above(hold_mask, out_port);
  assign hi_hold = highest_set(hold_mask);

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      hold_word  <= '0;
      hold_mask  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_port   <= '0;
      out_last   <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else if (clear) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_load)  rd_ptr <= rd_ptr + 1'b1;

      if (do_write && !do_load)      fifo_level <= fifo_level + 1'b1;
      else if (!do_write && do_load) fifo_level <= fifo_level - 1'b1;

      if (do_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end

      // Loading covers both the IDLE start and the back-to-back handoff after a last beat.
      if (do_load) begin
        state     <= SEND;
        out_valid <= 1'b1;
        hold_word <= head;
        hold_mask <= port_mask;
        out_port  <= lo_new;
        out_data  <= lane(head, lo_new);
        out_last  <= (lo_new == hi_new);
      end else if (fire && !out_last) begin
        out_port <= nx_idx;
        out_data <= lane(hold_word, nx_idx);
        out_last <= (nx_idx == hi_hold);
      end else if (fire) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_recorder_port_serializer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic compared every cycle against a queue-based reference model.
module tb_recorder_port_serializer;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int FD = 4;
  localparam int CW = 3;
  localparam int DROP_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic [31:0]   in_data;
  logic [3:0]    port_mask;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [1:0]    out_port;
  logic          out_last;
  logic [2:0]    fifo_level;
  logic          overflow;
  logic [CW-1:0] drop_cnt;

  recorder_port_serializer #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .DROP_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .port_mask(port_mask), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_port(out_port),
    .out_last(out_last), .fifo_level(fifo_level), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit use_model = 1'b0;

  // Reference model: pending words, the word being sent and its remaining ports.
  logic [31:0] mq[$];
  logic [31:0] mhold;
  int          mbeats[$];
  bit          mvalid;
  bit          mov;
  int          mdrop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mbeats.delete();
    mhold  = '0;
    mvalid = 1'b0;
    mov    = 1'b0;
    mdrop  = 0;
  endtask

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_edge();
    bit full, fire, finishing;
    if (clear) begin
      model_reset();
    end else begin
      full      = (mq.size() == FD);
      fire      = mvalid && out_ready;
      finishing = !mvalid || (fire && mbeats.size() == 1);
      if (fire) begin
        void'(mbeats.pop_front());
        if (mbeats.size() == 0) mvalid = 1'b0;
      end
      if (finishing && mq.size() > 0 && port_mask != 4'h0) begin
        mhold = mq.pop_front();
        mbeats.delete();
        for (int i = 0; i < NP; i++) if (port_mask[i]) mbeats.push_back(i);
        mvalid = 1'b1;
      end
      if (in_valid) begin
        if (full) begin
          mov = 1'b1;
          if (mdrop < DROP_MAX) mdrop++;
        end else begin
          mq.push_back(in_data);
        end
      end
    end
  endtask

  task automatic model_compare();
    int p;
    chk("m_valid", 32'(out_valid), 32'(mvalid));
    chk("m_level", 32'(fifo_level), 32'(mq.size()));
    chk("m_overflow", 32'(overflow), 32'(mov));
    chk("m_drop", 32'(drop_cnt), 32'(mdrop));
    if (mvalid) begin
      p = mbeats[0];
      chk("m_port", 32'(out_port), 32'(p));
      chk("m_data", 32'(out_data), 32'(mhold[(NP - 1 - p) * DW +: DW]));
      chk("m_last", 32'(out_last), 32'(mbeats.size() == 1));
    end
  endtask

  task automatic step();
    logic       pv, pr, pc, pl;
    logic [7:0] pd;
    logic [1:0] pp;
    pv = out_valid; pr = out_ready; pc = clear;
    pd = out_data;  pp = out_port;  pl = out_last;
    model_edge();
    @(posedge clk);
    #1;
    if (pv && !pr && !pc) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(pd));
      chk("stall_port", 32'(out_port), 32'(pp));
      chk("stall_last", 32'(out_last), 32'(pl));
    end
    if (use_model) model_compare();
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        rdy;
    logic        ev;
    logic [1:0]  ep;
    logic [7:0]  ed;
    logic        el;
    logic [2:0]  lvl;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic iv, input logic [31:0] d, input logic [3:0] m,
                     input logic ev, input logic [1:0] ep, input logic [7:0] ed,
                     input logic el, input logic [2:0] lvl);
    vec_t v;
    v = '{iv, d, m, 1'b1, ev, ep, ed, el, lvl};
    tbl.push_back(v);
  endtask

  initial begin
    int words;
    bit found;

    // Basic order, full mask
    add(1, 32'h11223344, 4'hF, 0, 0, 8'h00, 0, 1);
    add(0, 32'h0,        4'hF, 1, 0, 8'h11, 0, 0);
    add(0, 32'h0,        4'hF, 1, 1, 8'h22, 0, 0);
    add(0, 32'h0,        4'hF, 1, 2, 8'h33, 0, 0);
    add(0, 32'h0,        4'hF, 1, 3, 8'h44, 1, 0);
    // Sparse mask, back-to-back words
    add(0, 32'h0,        4'hA, 0, 0, 8'h00, 0, 0);
    add(1, 32'hAABBCCDD, 4'hA, 0, 0, 8'h00, 0, 1);
    add(1, 32'h01020304, 4'hA, 1, 1, 8'hBB, 0, 1);
    add(0, 32'h0,        4'hA, 1, 3, 8'hDD, 1, 1);
    add(0, 32'h0,        4'hA, 1, 1, 8'h02, 0, 0);
    add(0, 32'h0,        4'hA, 1, 3, 8'h04, 1, 0);
    // Zero mask parks words, then single-port mask drains them
    add(0, 32'h0,        4'h0, 0, 0, 8'h00, 0, 0);
    add(1, 32'hA1A2A3A4, 4'h0, 0, 0, 8'h00, 0, 1);
    add(1, 32'hB1B2B3B4, 4'h0, 0, 0, 8'h00, 0, 2);
    add(1, 32'hC1C2C3C4, 4'h0, 0, 0, 8'h00, 0, 3);
    add(0, 32'h0,        4'h0, 0, 0, 8'h00, 0, 3);
    add(0, 32'h0,        4'h1, 1, 0, 8'hA1, 1, 2);
    add(0, 32'h0,        4'h1, 1, 0, 8'hB1, 1, 1);
    add(0, 32'h0,        4'h1, 1, 0, 8'hC1, 1, 0);
    add(0, 32'h0,        4'h1, 0, 0, 8'h00, 0, 0);

    resetn = 1'b0; in_valid = 1'b0; in_data = '0; port_mask = '0;
    clear = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_port", 32'(out_port), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; in_data = tbl[i].data;
      port_mask = tbl[i].mask; out_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(tbl[i].lvl));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_port", i), 32'(out_port), 32'(tbl[i].ep));
        chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
        chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(tbl[i].el));
      end
    end
    in_valid = 1'b0;
    use_model = 1'b1;

    // Overflow: first word goes to the holding register, four fill the FIFO, one drops
    port_mask = 4'hF; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h01010101 * (i + 1);
      step();
    end
    in_valid = 1'b0;
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'd1);
    out_ready = 1'b1;
    words = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid && out_last) words++;
      step();
    end
    chk("ovf_words", 32'(words), 32'd5);

    // Clear with no pending input, then saturate the drop counter
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_overflow", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);
    port_mask = 4'h0;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      step();
    end
    in_valid = 1'b0;
    chk("sat_level", 32'(fifo_level), 32'd4);
    chk("sat_drop", 32'(drop_cnt), 32'(DROP_MAX));

    // Clear during the port 2 beat with in_valid high
    port_mask = 4'hF;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && out_port == 2'd2) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("reach_port2", 32'(found), 32'd1);
    clear = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("clrmid_valid", 32'(out_valid), 32'd0);
    chk("clrmid_level", 32'(fifo_level), 32'd0);
    chk("clrmid_overflow", 32'(overflow), 32'd0);
    chk("clrmid_drop", 32'(drop_cnt), 32'd0);
    in_valid = 1'b1; in_data = 32'h5A6B7C8D;
    step();
    in_valid = 1'b0;
    step();
    chk("restart_valid", 32'(out_valid), 32'd1);
    chk("restart_port", 32'(out_port), 32'd0);
    chk("restart_data", 32'(out_data), 32'h5A);

    // Asynchronous reset while a word is being sent
    step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_port", 32'(out_port), 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Randomized traffic, backpressure, mask changes and occasional clears
    port_mask = 4'hF;
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      in_data   = $urandom;
      out_ready = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 63) == 0) port_mask = 4'($urandom_range(0, 15));
      clear     = ($urandom_range(0, 99) == 0);
      step();
    end
    clear = 1'b0; in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
